// File: rtl/bpsk_burst_gen.sv
// BPSK burst stimulus generator: NCO phase accumulator driving an external cosine LUT,
// sign-flipped per symbol, emitting a pure-carrier preamble followed by a selectable payload.
module bpsk_burst_gen #(
  parameter int         ANGLE_W         = 12,
  parameter int         SAMPLE_W        = 16,
  parameter int         SAMPLES_PER_SYM = 100,
  parameter int         PREAMBLE_SYMS   = 32,
  parameter logic [6:0] PRBS_SEED       = 7'h7F
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [ANGLE_W-1:0]         phase_offset,
  input  logic [ANGLE_W-1:0]         tuning_word,
  input  logic [15:0]                burst_symbols,
  input  logic [1:0]                 mode,
  input  logic                       ext_bit,
  output logic [ANGLE_W-1:0]         lut_angle,
  input  logic signed [SAMPLE_W-1:0] lut_value,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       sample_valid,
  output logic                       symbol_bit,
  output logic                       symbol_strobe,
  output logic                       busy,
  output logic                       done
);

  localparam int CNT_W = (SAMPLES_PER_SYM > 1) ? $clog2(SAMPLES_PER_SYM) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLES_PER_SYM - 1);
  localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_SYMS - 1);
  localparam logic signed [SAMPLE_W-1:0] S_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic signed [SAMPLE_W-1:0] S_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREAMBLE,
    S_PAYLOAD,
    S_DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [CNT_W-1:0]   sample_cnt;
  logic [15:0]        sym_cnt;
  logic [ANGLE_W-1:0] tw_q;
  logic [15:0]        burst_q;
  logic [1:0]         mode_q;
  logic [6:0]         lfsr;
  logic [6:0]         lfsr_next;
  logic               alt_toggle;
  logic               alt_next;
  logic               cur_bit;
  logic               bit_now;
  logic               sym_first;
  logic               sample_last;
  logic               phase_end;
  logic               accept;
  logic               gen;
  logic signed [SAMPLE_W-1:0] neg_value;

  always_comb begin
    state_next  = state;
    bit_now     = cur_bit;
    lfsr_next   = lfsr;
    alt_next    = alt_toggle;
    sym_first   = (sample_cnt == '0);
    sample_last = (sample_cnt == CNT_LAST);
    phase_end   = 1'b0;
    accept      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (PREAMBLE_SYMS > 0)
            state_next = S_PREAMBLE;
          else if (burst_symbols != 16'd0)
            state_next = S_PAYLOAD;
          else
            state_next = S_DONE;
        end
      end
      S_PREAMBLE: begin
        if (sym_first)
          bit_now = 1'b0;
        phase_end = sample_last && (sym_cnt == PRE_LAST);
        if (phase_end)
          state_next = (burst_q != 16'd0) ? S_PAYLOAD : S_DONE;
      end
      S_PAYLOAD: begin
        // A new payload bit is fetched only on the first sample of each symbol
        if (sym_first) begin
          case (mode_q)
            2'd0: begin
              bit_now   = lfsr[6];
              lfsr_next = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
            end
            2'd1: bit_now = 1'b0;
            2'd2: begin
              bit_now  = alt_toggle;
              alt_next = ~alt_toggle;
            end
            default: bit_now = ext_bit;
          endcase
        end
        phase_end = sample_last && (sym_cnt == burst_q - 16'd1);
        if (phase_end)
          state_next = S_DONE;
      end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (abort) begin
      state_next = S_IDLE;
      accept     = 1'b0;
    end
  end

  assign gen       = ((state == S_PREAMBLE) || (state == S_PAYLOAD)) && !abort;
  assign neg_value = (lut_value == S_MIN) ? S_MAX : -lut_value;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      lut_angle     <= '0;
      sample_cnt    <= '0;
      sym_cnt       <= '0;
      tw_q          <= '0;
      burst_q       <= '0;
      mode_q        <= '0;
      lfsr          <= PRBS_SEED;
      alt_toggle    <= 1'b0;
      cur_bit       <= 1'b0;
      sample_out    <= '0;
      sample_valid  <= 1'b0;
      symbol_bit    <= 1'b0;
      symbol_strobe <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        lut_angle  <= phase_offset;
        tw_q       <= tuning_word;
        burst_q    <= burst_symbols;
        mode_q     <= mode;
        lfsr       <= PRBS_SEED;
        alt_toggle <= 1'b0;
        sample_cnt <= '0;
        sym_cnt    <= '0;
      end else if (gen) begin
        lut_angle  <= lut_angle + tw_q;
        lfsr       <= lfsr_next;
        alt_toggle <= alt_next;
        cur_bit    <= bit_now;
        sample_cnt <= sample_last ? '0 : sample_cnt + 1'b1;
        if (phase_end)
          sym_cnt <= '0;
        else if (sample_last)
          sym_cnt <= sym_cnt + 16'd1;
      end
      // Output stage is one clock behind the LUT address, so the final sample lands in DONE
      if (gen) begin
        sample_out    <= bit_now ? neg_value : lut_value;
        sample_valid  <= 1'b1;
        symbol_bit    <= bit_now;
        symbol_strobe <= sym_first;
      end else begin
        sample_out    <= '0;
        sample_valid  <= 1'b0;
        symbol_bit    <= 1'b0;
        symbol_strobe <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bpsk_burst_gen.sv
// Randomized self-checking bench for bpsk_burst_gen; expectations come from a sample-index
// model (angle = phase + n*tw, bit from symbol index, PRBS from its output recurrence).
module tb_bpsk_burst_gen;
  localparam int AW  = 12;
  localparam int SW  = 16;
  localparam int SPS = 4;
  localparam int PRE = 2;
  localparam logic [6:0] SEED = 7'h7F;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [AW-1:0]  phase_offset = '0;
  logic [AW-1:0]  tuning_word = '0;
  logic [15:0]    burst_symbols = '0;
  logic [1:0]     mode = '0;
  logic           ext_bit = 1'b0;
  logic [AW-1:0]  lut_angle;
  logic signed [SW-1:0] lut_value;
  logic signed [SW-1:0] sample_out;
  logic           sample_valid;
  logic           symbol_bit;
  logic           symbol_strobe;
  logic           busy;
  logic           done;
  logic           force_min = 1'b0;

  int checks = 0;
  int fails  = 0;

  int cap_sample[$];
  bit cap_bit[$];
  bit cap_strobe[$];
  int cap_angle[$];
  bit ext_hist[$];
  int exp_sample[$];
  bit exp_bit[$];
  bit exp_strobe[$];
  int exp_angle[$];
  int done_cnt;
  int done_idx;
  int idle_idx;
  bit done_valid;
  bit timed_out;

  bpsk_burst_gen #(
    .ANGLE_W(AW), .SAMPLE_W(SW), .SAMPLES_PER_SYM(SPS),
    .PREAMBLE_SYMS(PRE), .PRBS_SEED(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .phase_offset(phase_offset), .tuning_word(tuning_word),
    .burst_symbols(burst_symbols), .mode(mode), .ext_bit(ext_bit),
    .lut_angle(lut_angle), .lut_value(lut_value), .sample_out(sample_out),
    .sample_valid(sample_valid), .symbol_bit(symbol_bit),
    .symbol_strobe(symbol_strobe), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Linear ramp LUT stand-in: angle 0 maps to the most negative sample value
  function automatic logic signed [SW-1:0] lut_fn(input logic [AW-1:0] a);
    int v;
    v = int'(a) * 16 - 32768;
    return SW'(v);
  endfunction

  always_comb lut_value = force_min ? 16'sh8000 : lut_fn(lut_angle);

  function automatic int sneg(input int v);
    return (v == -32768) ? 32767 : -v;
  endfunction

  task automatic start_burst(input int ph, input int tw, input int b, input int m);
    phase_offset  = AW'(ph);
    tuning_word   = AW'(tw);
    burst_symbols = 16'(b);
    mode          = 2'(m);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic capture(input int max_cycles, input bit poke);
    cap_sample.delete(); cap_bit.delete(); cap_strobe.delete();
    cap_angle.delete(); ext_hist.delete();
    timed_out = 1'b1; done_cnt = 0; done_idx = -1; idle_idx = -1; done_valid = 1'b0;
    for (int c = 0; c < max_cycles; c++) begin
      cap_angle.push_back(int'(lut_angle));
      if (sample_valid) begin
        cap_sample.push_back(int'(sample_out));
        cap_bit.push_back(symbol_bit);
        cap_strobe.push_back(symbol_strobe);
      end
      if (done) begin
        done_cnt++;
        if (done_idx < 0) begin
          done_idx = c;
          done_valid = sample_valid;
        end
      end
      if (!busy) begin
        idle_idx = c;
        timed_out = 1'b0;
        break;
      end
      ext_bit = 1'($urandom_range(0, 1));
      ext_hist.push_back(ext_bit);
      start = poke && (c == 5 || done);
      if (start) begin
        phase_offset  = AW'($urandom);
        tuning_word   = AW'($urandom);
        burst_symbols = 16'($urandom_range(1, 9));
        mode          = 2'($urandom_range(0, 3));
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic build_model(input int ph, input int tw, input int b, input int m, input bit fm);
    bit prbs[$];
    int n_tot;
    int s;
    int lv;
    bit bt;
    exp_sample.delete(); exp_bit.delete(); exp_strobe.delete(); exp_angle.delete();
    for (int i = 6; i >= 0; i--) prbs.push_back(SEED[i]);
    for (int k = 0; prbs.size() < b + 8; k++) prbs.push_back(prbs[k] ^ prbs[k+1]);
    n_tot = (PRE + b) * SPS;
    for (int n = 0; n < n_tot; n++) begin
      s = n / SPS;
      if (s < PRE) bt = 1'b0;
      else begin
        case (m)
          0: bt = prbs[s-PRE];
          1: bt = 1'b0;
          2: bt = 1'((s - PRE) % 2);
          default: bt = ext_hist[s*SPS];
        endcase
      end
      lv = fm ? -32768 : int'(lut_fn(AW'((ph + n * tw) % 4096)));
      exp_sample.push_back(bt ? sneg(lv) : lv);
      exp_bit.push_back(bt);
      exp_strobe.push_back((n % SPS) == 0);
    end
    for (int c = 0; c <= n_tot; c++) exp_angle.push_back((ph + c * tw) % 4096);
    exp_angle.push_back((ph + n_tot * tw) % 4096);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b1;
    phase_offset = 12'd999;
    repeat (5) @(negedge clk);
    checks++; if (lut_angle !== 12'd0) begin fails++; $display("[TB] FAIL reset_angle: got %0d, expected 0", lut_angle); end
    checks++; if (sample_out !== 16'sd0) begin fails++; $display("[TB] FAIL reset_sample: got %0d, expected 0", sample_out); end
    checks++; if ({sample_valid, symbol_bit, symbol_strobe} !== 3'b000) begin fails++; $display("[TB] FAIL reset_flags: got %b, expected 000", {sample_valid, symbol_bit, symbol_strobe}); end
    checks++; if ({busy, done} !== 2'b00) begin fails++; $display("[TB] FAIL reset_busy_done: got %b, expected 00", {busy, done}); end
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_preamble_alt;
    int bad;
    int strobes;
    start_burst(1235, 256, 3, 2);
    capture(200, 1'b0);
    build_model(1235, 256, 3, 2, 1'b0);
    checks++; if (timed_out) begin fails++; $display("[TB] FAIL t2_timeout: burst still busy, expected completion"); end
    checks++; if (cap_angle.size() < 3 || cap_angle[0] != 1235 || cap_angle[1] != 1491 || cap_angle[2] != 1747) begin
      fails++; $display("[TB] FAIL t2_first_angles: got %0d,%0d, expected 1235,1491", cap_angle[0], cap_angle[1]); end
    checks++; if (cap_sample.size() != 20) begin fails++; $display("[TB] FAIL t2_valid_count: got %0d, expected 20", cap_sample.size()); end
    bad = -1;
    for (int n = 0; n < cap_sample.size() && n < exp_sample.size(); n++)
      if (cap_sample[n] != exp_sample[n] || cap_bit[n] != exp_bit[n] || cap_strobe[n] != exp_strobe[n]) begin bad = n; break; end
    checks++; if (bad >= 0) begin fails++; $display("[TB] FAIL t2_samples: idx %0d got %0d/%0b/%0b, expected %0d/%0b/%0b", bad, cap_sample[bad], cap_bit[bad], cap_strobe[bad], exp_sample[bad], exp_bit[bad], exp_strobe[bad]); end
    strobes = 0;
    foreach (cap_strobe[i]) if (cap_strobe[i]) strobes++;
    checks++; if (strobes != 5) begin fails++; $display("[TB] FAIL t2_strobes: got %0d, expected 5", strobes); end
    checks++; if (done_cnt != 1 || !done_valid) begin fails++; $display("[TB] FAIL t2_done: got %0d pulses valid=%0b, expected 1 with valid=1", done_cnt, done_valid); end
    checks++; if (idle_idx != done_idx + 1) begin fails++; $display("[TB] FAIL t2_busy_after_done: idle at %0d, expected %0d", idle_idx, done_idx + 1); end
  endtask

  task automatic test_wrap_sat;
    int bad;
    force_min = 1'b1;
    start_burst(0, 4095, 2, 0);
    capture(200, 1'b0);
    build_model(0, 4095, 2, 0, 1'b1);
    force_min = 1'b0;
    checks++; if (cap_angle.size() < 3 || cap_angle[1] != 4095 || cap_angle[2] != 4094) begin
      fails++; $display("[TB] FAIL t3_wrap: got %0d,%0d, expected 4095,4094", cap_angle[1], cap_angle[2]); end
    checks++; if (cap_sample.size() <= 8 || cap_sample[8] != 32767) begin
      fails++; $display("[TB] FAIL t3_saturate: got %0d, expected 32767", cap_sample.size() > 8 ? cap_sample[8] : 0); end
    bad = -1;
    for (int n = 0; n < exp_sample.size(); n++)
      if (n >= cap_sample.size() || cap_sample[n] != exp_sample[n]) begin bad = n; break; end
    checks++; if (bad >= 0) begin fails++; $display("[TB] FAIL t3_samples: first bad idx %0d, expected %0d", bad, exp_sample[bad]); end
  endtask

  task automatic test_prbs;
    int ph;
    int tw;
    int bad;
    ph = $urandom_range(0, 4095);
    tw = $urandom_range(0, 4095);
    start_burst(ph, tw, 128, 0);
    capture(1000, 1'b0);
    build_model(ph, tw, 128, 0, 1'b0);
    checks++; if (cap_sample.size() != exp_sample.size()) begin fails++; $display("[TB] FAIL t4_count: got %0d, expected %0d", cap_sample.size(), exp_sample.size()); end
    bad = -1;
    for (int n = 0; n < cap_sample.size() && n < exp_sample.size(); n++)
      if (cap_bit[n] != exp_bit[n] || cap_sample[n] != exp_sample[n]) begin bad = n; break; end
    checks++; if (bad >= 0) begin fails++; $display("[TB] FAIL t4_prbs: idx %0d got bit %0b, expected %0b", bad, cap_bit[bad], exp_bit[bad]); end
    checks++; if (cap_bit.size() > (PRE + 127) * SPS && cap_bit[(PRE + 127) * SPS] != 1'b1) begin
      fails++; $display("[TB] FAIL t4_period: got %0b at symbol 128, expected 1", cap_bit[(PRE + 127) * SPS]); end
  endtask

  task automatic test_random_bursts;
    int ph, tw, b, m, bad, badang;
    for (int r = 0; r < 8; r++) begin
      ph = $urandom_range(0, 4095);
      tw = $urandom_range(0, 4095);
      b  = $urandom_range(0, 6);
      m  = $urandom_range(0, 3);
      start_burst(ph, tw, b, m);
      capture(200, 1'b0);
      build_model(ph, tw, b, m, 1'b0);
      checks++; if (cap_sample.size() != exp_sample.size() || done_cnt != 1) begin
        fails++; $display("[TB] FAIL rand%0d_count: got %0d samples %0d done, expected %0d and 1", r, cap_sample.size(), done_cnt, exp_sample.size()); end
      bad = -1;
      for (int n = 0; n < cap_sample.size() && n < exp_sample.size(); n++)
        if (cap_sample[n] != exp_sample[n] || cap_bit[n] != exp_bit[n] || cap_strobe[n] != exp_strobe[n]) begin bad = n; break; end
      checks++; if (bad >= 0) begin fails++; $display("[TB] FAIL rand%0d_samples: mode %0d idx %0d got %0d/%0b, expected %0d/%0b", r, m, bad, cap_sample[bad], cap_bit[bad], exp_sample[bad], exp_bit[bad]); end
      badang = -1;
      for (int c = 0; c < cap_angle.size() && c < exp_angle.size(); c++)
        if (cap_angle[c] != exp_angle[c]) begin badang = c; break; end
      checks++; if (badang >= 0) begin fails++; $display("[TB] FAIL rand%0d_angle: cycle %0d got %0d, expected %0d", r, badang, cap_angle[badang], exp_angle[badang]); end
    end
  endtask

  task automatic test_abort;
    int ph, bad, seen_done;
    // abort and start together while idle: abort must win
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL abort_vs_start: busy got %0b, expected 0", busy); end
    start_burst(100, 37, 10, 0);
    repeat (15) @(negedge clk);
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    checks++; if ({sample_valid, busy, done} !== 3'b000) begin fails++; $display("[TB] FAIL abort_next: valid/busy/done got %b, expected 000", {sample_valid, busy, done}); end
    seen_done = 0;
    for (int c = 0; c < 20; c++) begin
      if (done || sample_valid) seen_done++;
      @(negedge clk);
    end
    checks++; if (seen_done != 0) begin fails++; $display("[TB] FAIL abort_quiet: got %0d active cycles, expected 0", seen_done); end
    ph = $urandom_range(0, 4095);
    start_burst(ph, 300, 3, 0);
    capture(200, 1'b0);
    build_model(ph, 300, 3, 0, 1'b0);
    bad = -1;
    for (int n = 0; n < exp_sample.size(); n++)
      if (n >= cap_sample.size() || cap_sample[n] != exp_sample[n] || cap_bit[n] != exp_bit[n]) begin bad = n; break; end
    checks++; if (bad >= 0 || cap_angle[0] != ph) begin fails++; $display("[TB] FAIL abort_restart: idx %0d angle0 %0d, expected clean burst from %0d", bad, cap_angle[0], ph); end
  endtask

  task automatic test_back_to_back;
    int bad;
    start_burst(2000, 123, 4, 2);
    capture(200, 1'b1);
    build_model(2000, 123, 4, 2, 1'b0);
    bad = -1;
    for (int n = 0; n < exp_sample.size(); n++)
      if (n >= cap_sample.size() || cap_sample[n] != exp_sample[n] || cap_bit[n] != exp_bit[n]) begin bad = n; break; end
    checks++; if (bad >= 0 || cap_sample.size() != exp_sample.size()) begin fails++; $display("[TB] FAIL b2b_ignore_start: idx %0d, got %0d samples, expected %0d", bad, cap_sample.size(), exp_sample.size()); end
    checks++; if (timed_out || idle_idx != done_idx + 1) begin fails++; $display("[TB] FAIL b2b_done_start: idle at %0d, expected %0d", idle_idx, done_idx + 1); end
    start_burst(77, 4000, 2, 1);
    capture(200, 1'b0);
    build_model(77, 4000, 2, 1, 1'b0);
    bad = -1;
    for (int n = 0; n < exp_sample.size(); n++)
      if (n >= cap_sample.size() || cap_sample[n] != exp_sample[n] || cap_strobe[n] != exp_strobe[n]) begin bad = n; break; end
    checks++; if (bad >= 0) begin fails++; $display("[TB] FAIL b2b_second: first bad idx %0d, expected %0d", bad, exp_sample[bad]); end
  endtask

  task automatic test_mid_reset;
    start_burst(555, 11, 5, 0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if ({busy, done, sample_valid, symbol_strobe} !== 4'b0000 || lut_angle !== 12'd0 || sample_out !== 16'sd0) begin
      fails++; $display("[TB] FAIL mid_reset: busy/done/valid/strobe %b angle %0d sample %0d, expected all 0", {busy, done, sample_valid, symbol_strobe}, lut_angle, sample_out); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_preamble_alt;
    test_wrap_sat;
    test_prbs;
    test_random_bursts;
    test_abort;
    test_back_to_back;
    test_mid_reset;
    test_preamble_alt;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
